// File: rtl/insn_fifo_pkg.sv
// Shared constants, count type and pointer-wrap helper for the instruction byte queue.
// ptr_add is also used by the decoder-side IP tracking.
package insn_fifo_pkg;

    localparam int INSN_FIFO_DEPTH = 6;
    localparam int INSN_FIFO_SLACK = 1;
    localparam int INSN_FIFO_CNT_W = $clog2(INSN_FIFO_DEPTH + 1);

    typedef logic [INSN_FIFO_CNT_W-1:0] insn_cnt_t;

    // Callers pass n <= depth, so one conditional subtract is enough to wrap.
    function automatic int ptr_add(input int ptr, input int n, input int depth);
        return (ptr + n >= depth) ? (ptr + n - depth) : (ptr + n);
    endfunction

endpackage

// File: rtl/insn_fifo.sv
// Instruction byte queue between prefetch and decode.
// Takes one byte in per cycle, shows a 2-byte little-endian lookahead, and lets the consumer pop 1 or 2 bytes.
module insn_fifo
    import insn_fifo_pkg::*;
#(
    parameter int DEPTH      = INSN_FIFO_DEPTH,
    parameter int FULL_SLACK = INSN_FIFO_SLACK
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         full,
    input  logic                         rd_en,
    input  logic                         rd_word,
    output logic [15:0]                  rd_data,
    output logic                         byte_valid,
    output logic                         word_valid,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtrNext;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] countAfterPop;
    logic          overflow_q, overflow_d;
    logic [1:0]    popN;
    logic          pushOk;

    // A pop that asks for more bytes than are held is simply ignored.
    // The pop is applied before the push, so a same-cycle pop frees a slot for the push.
    always_comb begin
        popN = 2'd0;
        if (rd_en && rd_word && count_q >= CW'(2)) begin
            popN = 2'd2;
        end else if (rd_en && !rd_word && count_q >= CW'(1)) begin
            popN = 2'd1;
        end
        countAfterPop = count_q - CW'(popN);
        pushOk        = wr_en && !flush && (countAfterPop < CW'(DEPTH));

        rdPtr_d    = PW'(ptr_add(int'(rdPtr_q), int'(popN), DEPTH));
        wrPtr_d    = pushOk ? PW'(ptr_add(int'(wrPtr_q), 1, DEPTH)) : wrPtr_q;
        count_d    = countAfterPop + CW'(pushOk);
        overflow_d = overflow_q | (wr_en && !flush && !pushOk);

        if (flush) begin
            rdPtr_d    = '0;
            wrPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= wr_data;
            end
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Flags come from the registered count only; there is no write-to-read bypass.
    always_comb begin
        rdPtrNext  = PW'(ptr_add(int'(rdPtr_q), 1, DEPTH));
        rd_data    = {mem_q[rdPtrNext], mem_q[rdPtr_q]};
        count      = count_q;
        overflow   = overflow_q;
        empty      = (count_q == '0);
        byte_valid = (count_q >= CW'(1));
        word_valid = (count_q >= CW'(2));
        full       = (count_q >= CW'(DEPTH - FULL_SLACK));
    end

endmodule

// File: doc/insn_fifo.md
Name: insn_fifo

Overview:
Instruction byte queue between the prefetch unit and the decoder/immediate reader.
- Accepts one byte per cycle from prefetch.
- Presents the oldest two bytes, first-word-fall-through, as a little-endian lookahead word.
- Lets the consumer pop 1 or 2 bytes per cycle.
- Provides headroom so a word fetch already in flight, whose second byte arrives one cycle late, never overflows.

Parameters:
- DEPTH, 6, storage bytes; any value >= 3 (need not be a power of two).
- FULL_SLACK, 1, bytes kept free when full asserts; full = (count >= DEPTH - FULL_SLACK).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all contents (driven by prefetch fifo_reset)
- wr_en  input  1  push wr_data
- wr_data  input  8  byte to push
- full  output  1  prefetch must not start a new memory access
- rd_en  input  1  pop request
- rd_word  input  1  with rd_en: 1 pops 2 bytes, 0 pops 1 byte
- rd_data  output  16  [7:0] = oldest byte, [15:8] = next oldest
- byte_valid  output  1  count >= 1
- word_valid  output  1  count >= 2
- empty  output  1  count == 0
- count  output  $clog2(DEPTH+1)  bytes held
- overflow  output  1  sticky: a push was dropped

Behaviour:
- State: byte array mem[DEPTH], rd_ptr/wr_ptr in 0..DEPTH-1, count in 0..DEPTH, sticky overflow flag.
- Reset (async): pointers 0, count 0, mem all 0, overflow 0.
  - Resulting outputs: empty=1, full=0, byte_valid=0, word_valid=0, rd_data=16'h0000.
- Pointer increment wraps DEPTH-1 -> 0. A 2-byte advance wraps modulo DEPTH (e.g. DEPTH=6: 5+2 -> 1).
- Push acceptance: the push is accepted when wr_en && !flush && count_after_pop < DEPTH.
  - count_after_pop = count - pop_n.
  - A same-cycle pop frees space for the push.
- Overflow: wr_en with no room and no flush drops the byte, leaves all state unchanged, and sets overflow.
- Pop acceptance:
  - pop_n = 2 when rd_en && rd_word && count >= 2.
  - pop_n = 1 when rd_en && !rd_word && count >= 1.
  - Otherwise pop_n = 0: insufficient data is ignored, with no partial pop and no error.
- Simultaneous push and pop:
  - count_next = count + push - pop_n.
  - Pointers advance independently.
  - The pushed byte is written at the old wr_ptr.
- No write-to-read bypass: a byte pushed into an empty queue appears on rd_data and byte_valid in the following cycle. Read latency is 1 cycle from push.
- rd_data is combinational from mem[rd_ptr] and mem[rd_ptr+1 mod DEPTH].
  - Upper byte is meaningful only when word_valid.
  - Lower byte is meaningful only when byte_valid.
- flush: highest priority. Next cycle pointers = 0, count = 0 and overflow = 0; mem is not cleared. Same-cycle wr_en/rd_en are ignored.
- Status flags full, empty, byte_valid and word_valid are decoded from the registered count, so they change only at clock edges.
- Default DEPTH=6, FULL_SLACK=1: full at count >= 5.
  - Prefetch may still land the second byte of an in-flight word, so count reaches 6 without overflow.
- Reset mid-operation: immediate return to reset state, regardless of pending rd_en/wr_en.

Decomposition:
- Package insn_fifo_pkg:
  - INSN_FIFO_DEPTH = 6 and INSN_FIFO_SLACK = 1.
  - typedef for the count width.
  - function ptr_add(ptr, n, depth) returning the wrapped pointer; shared by the decoder-side IP tracking.
- No sub-module: storage, pointers and count sit in one always_ff block, with status decode in an always_comb block.

Test Plan:
- Reset, then push 8'h11, 8'h22 on consecutive cycles; check the cycle after each push:
  - after the first: byte_valid=1, word_valid=0, rd_data[7:0]=8'h11;
  - after the second: word_valid=1, rd_data=16'h2211, count=2.
- Fill with 8'h01..8'h05 -> full=1 at count=5. One more push (8'h06) -> count=6, overflow=0. Push 8'h07 -> dropped, overflow=1, count stays 6.
- Word-pop wrap, DEPTH=6:
  - Stimulus: push 8'h01..8'h05, pop 4 as two word pops; push 8'hA0, 8'hA1, 8'hA2 so wr_ptr wraps 5 -> 0 -> 1.
  - Check rd_data=16'hA005 (bytes at indices 4 and 5).
  - Check again after popping 8'h05: 16'hA1A0.
- Simultaneous events: count=1 (byte 8'h33), push 8'h44 with a byte pop in the same cycle -> count stays 1, rd_data[7:0]=8'h44 next cycle. Word pop at count=1 -> ignored, count=1.
- Flush precedence: count=4 with flush, wr_en and rd_en all asserted -> next cycle count=0, empty=1, overflow cleared. Push 8'h55 -> rd_data[7:0]=8'h55 one cycle later.
- Reset mid-operation: assert reset asynchronously between edges while count=3 and full traffic is applied -> outputs return to reset values immediately, not at the next clock edge.
